// File: rtl/matmul_loader.sv
// Stream-to-operand-memory loader for the matrix-multiply engine: fills X then Y,
// starts the engine, waits for its done edge, then re-arms for the next frame.
module matmul_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned N          = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  y_wr_en,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic                  result_valid,
    output logic [7:0]            frame_count
);

    localparam int unsigned LAST_IDX = N * N - 1;

    typedef enum logic [1:0] {
        ST_FILL_X = 2'd0,
        ST_FILL_Y = 2'd1,
        ST_START  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mm_start_q, mm_start_d;
    logic                  x_we_q, x_we_d;
    logic                  y_we_q, y_we_d;
    logic [DATA_WIDTH-1:0] x_din_q, x_din_d;
    logic [DATA_WIDTH-1:0] y_din_q, y_din_d;
    logic [ADDR_WIDTH-1:0] x_addr_q, x_addr_d;
    logic [ADDR_WIDTH-1:0] y_addr_q, y_addr_d;
    logic                  mm_done_q;
    logic                  result_q, result_d;
    logic [7:0]            frame_q, frame_d;
    logic                  accept;
    logic                  last_word;

    assign accept    = in_valid && in_ready_q;
    assign last_word = (cnt_q == ADDR_WIDTH'(LAST_IDX));

    // Next-state, word counter and registered-output next values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_we_d   = 1'b0;
        y_we_d   = 1'b0;
        x_din_d  = x_din_q;
        y_din_d  = y_din_q;
        x_addr_d = x_addr_q;
        y_addr_d = y_addr_q;
        result_d = 1'b0;
        frame_d  = frame_q;

        case (state_q)
            ST_FILL_X: begin
                if (accept) begin
                    x_we_d   = 1'b1;
                    x_din_d  = in_data;
                    x_addr_d = cnt_q;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = ST_FILL_Y;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_FILL_Y: begin
                if (accept) begin
                    y_we_d   = 1'b1;
                    y_din_d  = in_data;
                    y_addr_d = cnt_q;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // mm_done_q was loaded in START, so a done level left over from the
                // previous run never looks like an edge here.
                if (mm_done && !mm_done_q) begin
                    result_d = 1'b1;
                    frame_d  = frame_q + 8'd1;
                    state_d  = ST_FILL_X;
                end
            end
            default: begin
                state_d = ST_FILL_X;
                cnt_d   = '0;
            end
        endcase

        in_ready_d = (state_d == ST_FILL_X) || (state_d == ST_FILL_Y);
        mm_start_d = (state_d == ST_START);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL_X;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            mm_start_q <= 1'b0;
            x_we_q     <= 1'b0;
            y_we_q     <= 1'b0;
            x_din_q    <= '0;
            y_din_q    <= '0;
            x_addr_q   <= '0;
            y_addr_q   <= '0;
            mm_done_q  <= 1'b0;
            result_q   <= 1'b0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            mm_start_q <= mm_start_d;
            x_we_q     <= x_we_d;
            y_we_q     <= y_we_d;
            x_din_q    <= x_din_d;
            y_din_q    <= y_din_d;
            x_addr_q   <= x_addr_d;
            y_addr_q   <= y_addr_d;
            mm_done_q  <= mm_done;
            result_q   <= result_d;
            frame_q    <= frame_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mm_start     = mm_start_q;
    assign x_wr_en      = x_we_q;
    assign y_wr_en      = y_we_q;
    assign x_din        = x_din_q;
    assign y_din        = y_din_q;
    assign x_addr       = x_addr_q;
    assign y_addr       = y_addr_q;
    assign result_valid = result_q;
    assign frame_count  = frame_q;

endmodule

// File: tb/tb_matmul_loader.sv
// Scoreboard bench for matmul_loader: accepts push expected writes, the monitor
// pops and compares them one cycle later; scenario tasks check control timing.
module tb_matmul_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned N  = 8;
    localparam int          NN = N * N;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_din;
    logic [AW-1:0] x_addr;
    logic          x_wr_en;
    logic [DW-1:0] y_din;
    logic [AW-1:0] y_addr;
    logic          y_wr_en;
    logic          mm_start;
    logic          mm_done;
    logic          result_valid;
    logic [7:0]    frame_count;

    matmul_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_din        (x_din),
        .x_addr       (x_addr),
        .x_wr_en      (x_wr_en),
        .y_din        (y_din),
        .y_addr       (y_addr),
        .y_wr_en      (y_wr_en),
        .mm_start     (mm_start),
        .mm_done      (mm_done),
        .result_valid (result_valid),
        .frame_count  (frame_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            is_y;
        int            addr;
        logic [DW-1:0] data;
        int            pcyc;
    } wr_t;

    wr_t sb[$];
    int  n_vec, n_err;
    int  cyc, m_cnt;
    bit  m_y, m_start_pend;
    int  n_acc, n_wr, n_ywr, n_start, n_result;
    int  exp_frames;

    // Per-cycle scoreboard and mm_start model, sampled on the falling edge
    task automatic scoreboard_monitor();
        wr_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                sb.delete();
                m_cnt        = 0;
                m_y          = 1'b0;
                m_start_pend = 1'b0;
            end else begin
                if (x_wr_en || y_wr_en) begin
                    n_wr++;
                    if (y_wr_en) n_ywr++;
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_write: write x_en=%0b y_en=%0b x_addr=%0d y_addr=%0d at cycle %0d, required no write",
                                 x_wr_en, y_wr_en, x_addr, y_addr, cyc);
                    end else begin
                        e = sb.pop_front();
                        if ({x_wr_en, y_wr_en} !== {!e.is_y, e.is_y} ||
                            (e.is_y ? {y_addr, y_din} : {x_addr, x_din}) !== {AW'(e.addr), e.data} ||
                            e.pcyc != cyc - 1) begin
                            n_err++;
                            $display("FAIL sb_write: got x_en=%0b y_en=%0b x=%0d:%h y=%0d:%h cycle %0d, required %s addr=%0d data=%h cycle %0d",
                                     x_wr_en, y_wr_en, x_addr, x_din, y_addr, y_din, cyc,
                                     e.is_y ? "Y" : "X", e.addr, e.data, e.pcyc + 1);
                        end
                    end
                end
                while (sb.size() > 0 && sb[0].pcyc < cyc) begin
                    e = sb.pop_front();
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_missing: no write at cycle %0d, required %s addr=%0d data=%h",
                             cyc, e.is_y ? "Y" : "X", e.addr, e.data);
                end
                n_vec++;
                if (mm_start !== m_start_pend) begin
                    n_err++;
                    $display("FAIL mm_start: got %0b at cycle %0d, required %0b", mm_start, cyc, m_start_pend);
                end
                if (mm_start === 1'b1) n_start++;
                if (result_valid === 1'b1) n_result++;
                m_start_pend = 1'b0;
                if (in_valid && in_ready) begin
                    n_acc++;
                    sb.push_back('{is_y: m_y, addr: m_cnt, data: in_data, pcyc: cyc});
                    if (m_cnt == NN - 1) begin
                        m_cnt = 0;
                        if (m_y) m_start_pend = 1'b1;
                        m_y = !m_y;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    endtask

    // Present one word after gap idle cycles and hold it until accepted
    task automatic offer(input logic [DW-1:0] d, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        in_data  = d;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!in_ready && t < 300);
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL offer_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (mm_start !== 1'b1 && t < 50);
        if (mm_start !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL start_timeout: mm_start=%0b after %0d cycles, required 1", mm_start, t);
        end
        @(posedge clock);
        #1;
    endtask

    // Engine model: drop done, raise it after delay cycles, check the completion pulse
    task automatic engine_done(input int delay);
        mm_done = 1'b0;
        repeat (delay) begin
            @(negedge clock);
            n_vec++;
            if (result_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL wait_idle: result_valid=%0b in_ready=%0b, required 0 0", result_valid, in_ready);
            end
            @(posedge clock);
            #1;
        end
        mm_done = 1'b1;
        @(negedge clock);
        n_vec++;
        if (result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL result_early: result_valid=%0b, required 0", result_valid);
        end
        @(negedge clock);
        n_vec++;
        if (result_valid !== 1'b1 || in_ready !== 1'b1 || frame_count !== 8'(exp_frames + 1)) begin
            n_err++;
            $display("FAIL completion: result_valid=%0b in_ready=%0b frame_count=%0d, required 1 1 %0d",
                     result_valid, in_ready, frame_count, exp_frames + 1);
        end
        exp_frames++;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_vec++;
        if (in_ready !== 1'b1 || x_wr_en !== 1'b0 || y_wr_en !== 1'b0 || x_din !== '0 || y_din !== '0 ||
            x_addr !== '0 || y_addr !== '0 || mm_start !== 1'b0 || result_valid !== 1'b0 || frame_count !== 8'd0) begin
            n_err++;
            $display("FAIL %s: rdy=%0b xe=%0b ye=%0b xd=%h yd=%h xa=%0d ya=%0d st=%0b rv=%0b fc=%0d, required 1 0 0 0 0 0 0 0 0 0",
                     tag, in_ready, x_wr_en, y_wr_en, x_din, y_din, x_addr, y_addr, mm_start, result_valid, frame_count);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset_values");
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if (in_ready !== 1'b1 || frame_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%0b frame_count=%0d, required 1 0", in_ready, frame_count);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) offer(32'hA5A5_0000 + DW'(i), 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("reset_async");
        @(posedge clock);
        #1;
        reset      = 1'b0;
        exp_frames = 0;
    endtask

    task automatic test_full_frame();
        int a0, w0, s0;
        a0 = n_acc;
        w0 = n_wr;
        s0 = n_start;
        for (int i = 0; i < 2 * NN; i++) offer(DW'(i), 0);
        wait_start();
        repeat (3) begin
            @(negedge clock);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ready_in_wait: in_ready=%0b, required 0", in_ready);
            end
        end
        n_vec++;
        if (n_acc - a0 != 2 * NN || n_wr - w0 != 2 * NN || n_start - s0 != 1) begin
            n_err++;
            $display("FAIL full_counts: accepts=%0d writes=%0d starts=%0d, required %0d %0d 1",
                     n_acc - a0, n_wr - w0, n_start - s0, 2 * NN, 2 * NN);
        end
        @(posedge clock);
        #1;
        engine_done(5);
    endtask

    task automatic test_backpressure();
        int a0, w0;
        a0 = n_acc;
        w0 = n_wr;
        for (int i = 0; i < 2 * NN; i++) offer($urandom, int'($urandom_range(0, 3)));
        wait_start();
        n_vec++;
        if (n_acc - a0 != 2 * NN || n_wr - w0 != n_acc - a0) begin
            n_err++;
            $display("FAIL bp_counts: accepts=%0d writes=%0d, required %0d %0d", n_acc - a0, n_wr - w0, 2 * NN, 2 * NN);
        end
        engine_done(4);
    endtask

    task automatic test_stale_done();
        int r0;
        r0 = n_result;
        for (int i = 0; i < 2 * NN; i++) offer(32'h8000_0000 | DW'(i * 7), 0);
        wait_start();
        repeat (3) begin
            @(negedge clock);
            n_vec++;
            if (result_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stale_done: result_valid=%0b with held done, required 0", result_valid);
            end
            @(posedge clock);
            #1;
        end
        engine_done(20);
        @(negedge clock);
        n_vec++;
        if (n_result - r0 != 1 || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stale_pulses: pulses=%0d result_valid=%0b, required 1 0", n_result - r0, result_valid);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wait_hold();
        int a0;
        for (int i = 0; i < 2 * NN; i++) offer(DW'(1000 + i), int'($urandom_range(0, 1)));
        wait_start();
        a0       = n_acc;
        in_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        engine_done(8);
        in_valid = 1'b0;
        @(negedge clock);
        n_vec++;
        if (x_wr_en !== 1'b1 || x_addr !== '0 || x_din !== 32'hDEAD_BEEF || n_acc - a0 != 1) begin
            n_err++;
            $display("FAIL held_word: x_en=%0b x_addr=%0d x_din=%h accepts=%0d, required 1 0 deadbeef 1",
                     x_wr_en, x_addr, x_din, n_acc - a0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        int y0, s0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        exp_frames = 0;
        y0 = n_ywr;
        s0 = n_start;
        for (int i = 0; i < 30; i++) offer(DW'(5000 + i), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        n_vec++;
        if (n_ywr != y0 || n_start != s0 || frame_count !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: y_writes=%0d starts=%0d frame_count=%0d in_ready=%0b, required 0 0 0 1",
                     n_ywr - y0, n_start - s0, frame_count, in_ready);
        end
        for (int i = 0; i < 2 * NN; i++) offer(DW'(9000 + i), 0);
        wait_start();
        engine_done(2);
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        mm_done  = 1'b0;
        n_vec = 0; n_err = 0; cyc = 0; m_cnt = 0; m_y = 1'b0; m_start_pend = 1'b0;
        n_acc = 0; n_wr = 0; n_ywr = 0; n_start = 0; n_result = 0; exp_frames = 0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_full_frame();
        test_backpressure();
        test_stale_done();
        test_wait_hold();
        test_reset_mid_frame();
        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
